rst_sequencer: RTL and testbench
================================

# rst_sequencer

Parametrised reset sequencer between the board reset pad and the demo-system subsystems (core, bus/memories, peripherals, debug). It asserts the reset asynchronously and releases it synchronously through a configurable synchroniser. After release it holds all domains in reset for a programmable time, then releases the output channels one at a time with a fixed stagger. It also re-enters the reset sequence on an external request (e.g. debug ndmreset) without a pad reset and records the cause of the last reset.

## Interface
- `NumOut`, 4: number of active-low reset output channels (>=1).
- `SyncStages`, 2: synchroniser flops on reset deassertion (>=2).
- `HoldCycles`, 16: cycles all outputs stay asserted after entering HOLD (>=1).
- `StaggerCycles`, 4: cycles between successive channel releases (>=1).
- `clk_sys_i`  in  1  system clock.
- `rst_sys_ni`  in  1  reset, asynchronous, active-low.
- `ext_rst_req_i`  in  1  synchronous reset request, level, active-high.
- `sw_rst_req_i`  in  1  synchronous software reset request, active-high. Present only with `RST_SEQ_SW_REQ_EN`.
- `rst_no`  out  NumOut  per-channel reset, active-low. Channel 0 is released first.
- `rst_done_o`  out  1  high when every channel is released.
- `rst_cause_o`  out  2  cause of the last reset: 0 = POR/pad, 1 = ext, 2 = sw.

## Operation
- FSM states: RESET, HOLD, RELEASE, RUN.
- Reset values: all `rst_no` = 0, `rst_done_o` = 0, `rst_cause_o` = 0, state = RESET. All outputs are registered.
- `rst_sys_ni` low clears the synchroniser and the FSM immediately, regardless of state.
- RESET -> HOLD on the first edge at which the synchroniser output is high. The hold counter is cleared.
- HOLD: the counter increments each cycle. After HoldCycles cycles in HOLD, the FSM goes to RELEASE and `rst_no[0]` goes high on that same edge.
- RELEASE: every StaggerCycles cycles, the next channel index goes high.
- The edge that releases `rst_no[NumOut-1]` also sets `rst_done_o` and moves the FSM to RUN.
- With NumOut = 1, HOLD goes directly to RUN.
- Request accepted in any of HOLD/RELEASE/RUN when `ext_rst_req_i` or `sw_rst_req_i` is high:
  - next edge: all `rst_no` = 0, `rst_done_o` = 0, state HOLD, counter cleared;
  - `rst_cause_o` is updated on that edge.
- Request held high: the FSM stays in HOLD with the counter held at 0. The hold time is counted from the deassertion of the request.
- Simultaneous ext and sw requests: cause = 1 (ext wins).
- A request in RESET is ignored.
- Counters are $clog2(max(HoldCycles, StaggerCycles)+1) bits wide and saturate-free. They are cleared on every state change and never wrap within a state.

## Timing
- E0 = first rising edge at which `rst_sys_ni` is sampled high.
- Synchroniser output goes high after edge E0+SyncStages-1. The FSM enters HOLD at E0+SyncStages.
- `rst_no[i]` rises at edge E0+SyncStages+HoldCycles+i*StaggerCycles.
  - With defaults: channel 0 at E0+18, channel 3 at E0+30. `rst_done_o` rises at E0+30.
- Request sampled at edge E, request deasserted before E+1: all outputs low after E. `rst_no[i]` rises at E+HoldCycles+i*StaggerCycles.
- Asynchronous assert: `rst_no` goes low with no clock dependency.
- Release latency from pad is deterministic to the cycle.

## Configuration
- `RST_SEQ_SW_REQ_EN` defined:
  - `sw_rst_req_i` port exists and is ORed into the request path;
  - cause 2 is reachable.
- `RST_SEQ_SW_REQ_EN` undefined:
  - the port is absent and only `ext_rst_req_i` triggers a sequence;
  - `rst_cause_o` never reports 2.

## Structure
- Package `rst_seq_pkg` holds:
  - `rst_state_e` (RESET, HOLD, RELEASE, RUN);
  - `rst_cause_e` (RstCausePor = 2'd0, RstCauseExt = 2'd1, RstCauseSw = 2'd2);
  - parameter sanity-check constants.
- Sub-module `rst_sync`:
  - SyncStages-deep asynchronous-assert, synchronous-deassert flop chain;
  - reused wherever a per-domain reset synchroniser is needed.
- The FSM, counters and output register stay in `rst_sequencer`.

## Test plan
- Pad reset with defaults: release `rst_sys_ni` before E0 -> `rst_no` = 4'b0001 after E0+18, 4'b1111 and `rst_done_o` = 1 after E0+30, `rst_cause_o` = 0.
- Pad reset mid-RELEASE: pull `rst_sys_ni` low at E0+22 -> `rst_no` = 0 immediately. The full sequence repeats from the new E0.
- One-cycle `ext_rst_req_i` in RUN at edge E -> `rst_no` = 0 after E, 4'b1111 after E+28, `rst_cause_o` = 1.
- `ext_rst_req_i` held 10 cycles in RELEASE -> outputs stay 0 throughout. Release timing is counted from the drop of the request.
- With `RST_SEQ_SW_REQ_EN`:
  - `sw_rst_req_i` alone -> cause 2;
  - `sw_rst_req_i` and `ext_rst_req_i` on the same edge -> cause 1.
- NumOut = 1, HoldCycles = 1: `rst_no[0]` and `rst_done_o` rise at E0+SyncStages+1.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer.
// The optional software reset request is enabled with RST_SEQ_SW_REQ_EN.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    RESET   = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } rst_state_e;

  typedef enum logic [1:0] {
    RstCausePor = 2'd0,
    RstCauseExt = 2'd1,
    RstCauseSw  = 2'd2
  } rst_cause_e;

  // Smallest legal values for the sequencer parameters.
  localparam int MinNumOut        = 1;
  localparam int MinSyncStages    = 2;
  localparam int MinHoldCycles    = 1;
  localparam int MinStaggerCycles = 1;

  // One counter serves both HOLD and RELEASE, so it is sized for the longer interval.
  function automatic int cnt_width(input int hold_cycles, input int stagger_cycles);
    int longest;
    longest = (hold_cycles > stagger_cycles) ? hold_cycles : stagger_cycles;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Asynchronous-assert, synchronous-deassert reset synchroniser.
// Output rises Stages-1 edges after the first edge that samples rst_ni high.
module rst_sync #(
  parameter int Stages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic rst_no
);

  logic [Stages-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], 1'b1};
    end
  end

  assign rst_no = sync_q[Stages-1];

endmodule

// File: rtl/rst_sequencer.sv
// Reset sequencer: holds all channels in reset, then releases them one by one.
// Define RST_SEQ_SW_REQ_EN to add the sw_rst_req_i software reset request.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NumOut        = 4,
  parameter int SyncStages    = 2,
  parameter int HoldCycles    = 16,
  parameter int StaggerCycles = 4
) (
  input  logic              clk_sys_i,
  input  logic              rst_sys_ni,
  input  logic              ext_rst_req_i,
`ifdef RST_SEQ_SW_REQ_EN
  input  logic              sw_rst_req_i,
`endif
  output logic [NumOut-1:0] rst_no,
  output logic              rst_done_o,
  output logic [1:0]        rst_cause_o,
  output logic [1:0]        state_o
);

  localparam int CntW = cnt_width(HoldCycles, StaggerCycles);
  localparam logic [CntW-1:0] HoldLast    = CntW'(HoldCycles - 1);
  localparam logic [CntW-1:0] StaggerLast = CntW'(StaggerCycles - 1);
  localparam logic [NumOut-1:0] FirstOut  = NumOut'(1);
  localparam bit SingleOut = (NumOut == 1);

  logic              sync_rst_n;
  logic              req;
  rst_cause_e        req_cause;
  rst_state_e        state_q;
  logic [CntW-1:0]   cnt_q;
  logic [NumOut-1:0] rst_q;
  logic [NumOut-1:0] next_rst;
  logic              done_q;
  rst_cause_e        cause_q;

  rst_sync #(
    .Stages (SyncStages)
  ) u_rst_sync (
    .clk_i  (clk_sys_i),
    .rst_ni (rst_sys_ni),
    .rst_no (sync_rst_n)
  );

  // External request wins when both arrive on the same edge.
  always_comb begin
    req       = ext_rst_req_i;
    req_cause = RstCauseExt;
`ifdef RST_SEQ_SW_REQ_EN
    req = ext_rst_req_i | sw_rst_req_i;
    if (!ext_rst_req_i) begin
      req_cause = RstCauseSw;
    end
`endif
  end

  assign next_rst = (rst_q << 1) | FirstOut;

  // The pad drives the async clear directly; a racy release is harmless because
  // RESET keeps every output at its reset value until the synchroniser is high.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      state_q <= RESET;
      cnt_q   <= '0;
      rst_q   <= '0;
      done_q  <= 1'b0;
      cause_q <= RstCausePor;
    end else if (req && (state_q != RESET)) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      rst_q   <= '0;
      done_q  <= 1'b0;
      cause_q <= req_cause;
    end else begin
      case (state_q)
        RESET: begin
          if (sync_rst_n) begin
            state_q <= HOLD;
            cnt_q   <= '0;
          end
        end
        HOLD: begin
          if (cnt_q == HoldLast) begin
            cnt_q <= '0;
            rst_q <= FirstOut;
            if (SingleOut) begin
              state_q <= RUN;
              done_q  <= 1'b1;
            end else begin
              state_q <= RELEASE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RELEASE: begin
          if (cnt_q == StaggerLast) begin
            cnt_q <= '0;
            rst_q <= next_rst;
            if (&next_rst) begin
              state_q <= RUN;
              done_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RUN: begin
          cnt_q <= '0;
        end
        default: begin
          state_q <= RESET;
        end
      endcase
    end
  end

  assign rst_no      = rst_q;
  assign rst_done_o  = done_q;
  assign rst_cause_o = cause_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: event-time reference model plus directed and random scenarios.
// Software-request scenarios are built when RST_SEQ_SW_REQ_EN is defined.
module tb_rst_sequencer;

  localparam int NumOut        = 4;
  localparam int SyncStages    = 2;
  localparam int HoldCycles    = 16;
  localparam int StaggerCycles = 4;
  localparam int W             = NumOut + 3;

  logic              clk       = 1'b0;
  logic              rst_sys_n = 1'b0;
  logic              ext_req   = 1'b0;
`ifdef RST_SEQ_SW_REQ_EN
  logic              sw_req    = 1'b0;
`endif
  logic [NumOut-1:0] rst_n;
  logic              rst_done;
  logic [1:0]        rst_cause;
  logic [1:0]        dut_state;
  logic              one_rst_n;
  logic              one_done;
  logic [1:0]        one_cause;
  logic [1:0]        one_state;

  int total = 0;
  int bad   = 0;

  // clock / reset
  always #5 clk = ~clk;

  rst_sequencer #(
    .NumOut        (NumOut),
    .SyncStages    (SyncStages),
    .HoldCycles    (HoldCycles),
    .StaggerCycles (StaggerCycles)
  ) u_dut (
    .clk_sys_i     (clk),
    .rst_sys_ni    (rst_sys_n),
    .ext_rst_req_i (ext_req),
`ifdef RST_SEQ_SW_REQ_EN
    .sw_rst_req_i  (sw_req),
`endif
    .rst_no        (rst_n),
    .rst_done_o    (rst_done),
    .rst_cause_o   (rst_cause),
    .state_o       (dut_state)
  );

  rst_sequencer #(
    .NumOut        (1),
    .SyncStages    (SyncStages),
    .HoldCycles    (1),
    .StaggerCycles (StaggerCycles)
  ) u_one (
    .clk_sys_i     (clk),
    .rst_sys_ni    (rst_sys_n),
    .ext_rst_req_i (ext_req),
`ifdef RST_SEQ_SW_REQ_EN
    .sw_rst_req_i  (sw_req),
`endif
    .rst_no        (one_rst_n),
    .rst_done_o    (one_done),
    .rst_cause_o   (one_cause),
    .state_o       (one_state)
  );

  // Reference model: a sequence starts at edge "start"; channel i is released
  // once the edge count reaches start + hold + i * stagger.
  int         edge_n  = 0;
  int         hi_cnt  = 0;
  int         start   = 0;
  bit         started = 1'b0;
  logic [1:0] m_cause = 2'd0;
  logic [W-1:0] exp_q[$];

  function automatic logic [NumOut-1:0] exp_rst();
    logic [NumOut-1:0] r;
    for (int i = 0; i < NumOut; i++)
      r[i] = started && (edge_n >= start + HoldCycles + i * StaggerCycles);
    return r;
  endfunction

  function automatic logic exp_done();
    return started && (edge_n >= start + HoldCycles + (NumOut - 1) * StaggerCycles);
  endfunction

  always @(negedge rst_sys_n) begin
    hi_cnt  = 0;
    started = 1'b0;
    m_cause = 2'd0;
  end

  always @(posedge clk) begin
    edge_n++;
    if (rst_sys_n) begin
      hi_cnt++;
      if (started) begin
        if (ext_req) begin
          start   = edge_n;
          m_cause = 2'd1;
        end
`ifdef RST_SEQ_SW_REQ_EN
        else if (sw_req) begin
          start   = edge_n;
          m_cause = 2'd2;
        end
`endif
      end else if (hi_cnt == SyncStages + 1) begin
        started = 1'b1;
        start   = edge_n;
      end
    end
    exp_q.push_back({exp_done(), m_cause, exp_rst()});
  end

  logic [W-1:0] exp;

  task automatic test_reset();
    rst_sys_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      while (exp_q.size() > 1) void'(exp_q.pop_front());
      exp = exp_q.pop_front();
      total++;
      if ({rst_done, rst_cause, rst_n} !== exp) begin
        bad++;
        $display("FAIL reset k=%0d got=%h exp=%h", k, {rst_done, rst_cause, rst_n}, exp);
      end
    end
    total++;
    if (rst_n !== '0 || rst_done !== 1'b0 || rst_cause !== 2'd0) begin
      bad++;
      $display("FAIL reset_values got rst=%b done=%b cause=%0d exp rst=0 done=0 cause=0",
               rst_n, rst_done, rst_cause);
    end
  endtask

  task automatic test_pad_reset();
    rst_sys_n = 1'b1;
    for (int k = 0; k <= 34; k++) begin
      @(negedge clk);
      while (exp_q.size() > 1) void'(exp_q.pop_front());
      exp = exp_q.pop_front();
      total++;
      if ({rst_done, rst_cause, rst_n} !== exp) begin
        bad++;
        $display("FAIL pad_seq k=%0d got=%h exp=%h", k, {rst_done, rst_cause, rst_n}, exp);
      end
      if (k == 17 || k == 18 || k == 29 || k == 30) begin
        total++;
        if ((k == 17 && {rst_done, rst_n} !== 5'b0_0000) ||
            (k == 18 && {rst_done, rst_n} !== 5'b0_0001) ||
            (k == 29 && {rst_done, rst_n} !== 5'b0_0111) ||
            (k == 30 && {rst_done, rst_n, rst_cause} !== 7'b1_1111_00)) begin
          bad++;
          $display("FAIL pad_timing E0+%0d got done=%b rst=%b cause=%0d", k, rst_done, rst_n, rst_cause);
        end
      end
    end
  endtask

  task automatic test_ext_pulse();
    @(negedge clk);
    ext_req = 1'b1;
    @(negedge clk);
    ext_req = 1'b0;
    for (int k = 0; k <= 30; k++) begin
      if (k > 0) @(negedge clk);
      while (exp_q.size() > 1) void'(exp_q.pop_front());
      exp = exp_q.pop_front();
      total++;
      if ({rst_done, rst_cause, rst_n} !== exp) begin
        bad++;
        $display("FAIL ext_pulse k=%0d got=%h exp=%h", k, {rst_done, rst_cause, rst_n}, exp);
      end
      if (k == 0 || k == 27 || k == 28) begin
        total++;
        if ((k == 0 && {rst_done, rst_n, rst_cause} !== 7'b0_0000_01) ||
            (k == 27 && {rst_done, rst_n} !== 5'b0_0111) ||
            (k == 28 && {rst_done, rst_n, rst_cause} !== 7'b1_1111_01)) begin
          bad++;
          $display("FAIL ext_timing E+%0d got done=%b rst=%b cause=%0d", k, rst_done, rst_n, rst_cause);
        end
      end
    end
  endtask

  task automatic test_ext_held();
    @(negedge clk);
    ext_req = 1'b1;
    @(negedge clk);
    ext_req = 1'b0;
    for (int k = 0; k <= 60; k++) begin
      if (k > 0) @(negedge clk);
      while (exp_q.size() > 1) void'(exp_q.pop_front());
      exp = exp_q.pop_front();
      total++;
      if ({rst_done, rst_cause, rst_n} !== exp) begin
        bad++;
        $display("FAIL ext_held k=%0d got=%h exp=%h", k, {rst_done, rst_cause, rst_n}, exp);
      end
      if ((k >= 21 && k <= 30) || k == 45 || k == 46 || k == 58) begin
        total++;
        if ((k <= 45 && {rst_done, rst_n} !== 5'b0_0000) ||
            (k == 46 && {rst_done, rst_n} !== 5'b0_0001) ||
            (k == 58 && {rst_done, rst_n} !== 5'b1_1111)) begin
          bad++;
          $display("FAIL ext_held_timing k=%0d got done=%b rst=%b", k, rst_done, rst_n);
        end
      end
      ext_req = (k >= 20 && k < 30);
    end
  endtask

  task automatic test_pad_mid_release();
    rst_sys_n = 1'b0;
    @(negedge clk);
    rst_sys_n = 1'b1;
    for (int k = 0; k <= 22; k++) begin
      @(negedge clk);
      while (exp_q.size() > 1) void'(exp_q.pop_front());
      exp = exp_q.pop_front();
      total++;
      if ({rst_done, rst_cause, rst_n} !== exp) begin
        bad++;
        $display("FAIL mid_release k=%0d got=%h exp=%h", k, {rst_done, rst_cause, rst_n}, exp);
      end
    end
    rst_sys_n = 1'b0;
    #1;
    total++;
    if (rst_n !== '0 || rst_done !== 1'b0) begin
      bad++;
      $display("FAIL async_assert got rst=%b done=%b exp rst=0000 done=0", rst_n, rst_done);
    end
    @(negedge clk);
    rst_sys_n = 1'b1;
    for (int k = 0; k <= 31; k++) begin
      @(negedge clk);
      while (exp_q.size() > 1) void'(exp_q.pop_front());
      exp = exp_q.pop_front();
      total++;
      if ({rst_done, rst_cause, rst_n} !== exp) begin
        bad++;
        $display("FAIL mid_repeat k=%0d got=%h exp=%h", k, {rst_done, rst_cause, rst_n}, exp);
      end
      if (k == 30) begin
        total++;
        if ({rst_done, rst_n, rst_cause} !== 7'b1_1111_00) begin
          bad++;
          $display("FAIL mid_repeat_done got done=%b rst=%b cause=%0d exp done=1 rst=1111 cause=0",
                   rst_done, rst_n, rst_cause);
        end
      end
    end
  endtask

`ifdef RST_SEQ_SW_REQ_EN
  task automatic test_sw_req();
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      sw_req  = 1'b1;
      ext_req = (pass == 1);
      @(negedge clk);
      sw_req  = 1'b0;
      ext_req = 1'b0;
      for (int k = 0; k <= 30; k++) begin
        if (k > 0) @(negedge clk);
        while (exp_q.size() > 1) void'(exp_q.pop_front());
        exp = exp_q.pop_front();
        total++;
        if ({rst_done, rst_cause, rst_n} !== exp) begin
          bad++;
          $display("FAIL sw_req pass=%0d k=%0d got=%h exp=%h", pass, k, {rst_done, rst_cause, rst_n}, exp);
        end
      end
      total++;
      if (rst_cause !== ((pass == 1) ? 2'd1 : 2'd2) || rst_done !== 1'b1) begin
        bad++;
        $display("FAIL sw_cause pass=%0d got cause=%0d done=%b", pass, rst_cause, rst_done);
      end
    end
  endtask
`endif

  task automatic test_single_channel();
    rst_sys_n = 1'b0;
    @(negedge clk);
    rst_sys_n = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      total++;
      if (one_rst_n !== (k >= SyncStages + 1) || one_done !== (k >= SyncStages + 1)) begin
        bad++;
        $display("FAIL single_channel E0+%0d got rst=%b done=%b exp=%b",
                 k, one_rst_n, one_done, (k >= SyncStages + 1));
      end
    end
  endtask

  task automatic test_random();
    int pad_low = 0;
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      while (exp_q.size() > 1) void'(exp_q.pop_front());
      exp = exp_q.pop_front();
      total++;
      if ({rst_done, rst_cause, rst_n} !== exp) begin
        bad++;
        $display("FAIL random k=%0d got=%h exp=%h", k, {rst_done, rst_cause, rst_n}, exp);
      end
      if (pad_low > 0) begin
        pad_low--;
        rst_sys_n = (pad_low == 0);
      end else if ($urandom_range(0, 249) == 0) begin
        pad_low   = $urandom_range(1, 3);
        rst_sys_n = 1'b0;
      end
      ext_req = ($urandom_range(0, 59) == 0) ||
                (ext_req && $urandom_range(0, 3) != 0);
`ifdef RST_SEQ_SW_REQ_EN
      sw_req = ($urandom_range(0, 59) == 0);
`endif
    end
    ext_req   = 1'b0;
    rst_sys_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_pad_reset();
    test_ext_pulse();
    test_ext_held();
    test_pad_mid_release();
`ifdef RST_SEQ_SW_REQ_EN
    test_sw_req();
`endif
    test_single_channel();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
